// File: rtl/ats21_pkg.sv
// Shared types and constants for the ATS21 alarm collector.
// Optional feature macro: ATS21_ALARM_TS_EN adds a timestamp field to each event.
package ats21_pkg;

  localparam int NUM_ALARMS = 24;
  localparam int ID_W       = $clog2(NUM_ALARMS);
  localparam int TS_W       = 16;

  typedef logic [NUM_ALARMS-1:0] alarm_vec_t;

  // One queued event: alarm number, plus its capture time when timestamps are built in.
  typedef struct packed {
`ifdef ATS21_ALARM_TS_EN
    logic [TS_W-1:0] ts;
`endif
    logic [ID_W-1:0] id;
  } alarm_evt_t;

endpackage

// File: rtl/ats21_evt_fifo.sv
// First-word fall-through event FIFO for the alarm collector.
// Optional feature macro: ATS21_ALARM_TS_EN (widens alarm_evt_t via the package).
module ats21_evt_fifo
  import ats21_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  alarm_evt_t push_data,
  input  logic       pop,
  output alarm_evt_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  alarm_evt_t         r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (PTR_W+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept a push.
  assign w_do_push = push & (~full | w_do_pop);

  // Head is forced to zero while empty so the outputs are defined straight out of reset.
  assign pop_data = empty ? alarm_evt_t'('0) : r_mem[r_rd_ptr];

  // Storage write; no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ats21_alarm_collector.sv
// Collects ATS21 "finished" pulses into single events, queues alarm IDs and
// presents them over valid/ready with a level irq.
// Optional feature macro: ATS21_ALARM_TS_EN adds per-event timestamps on evt_ts.
module ats21_alarm_collector
  import ats21_pkg::alarm_evt_t;
#(
  parameter int NUM_ALARMS = 24,
  parameter int ID_W       = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter int TS_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_ALARMS-1:0] alarm_in,
  input  logic                  mask_wr,
  input  logic [NUM_ALARMS-1:0] mask_data,
  output logic                  evt_valid,
  output logic [ID_W-1:0]       evt_id,
  input  logic                  evt_ready,
  output logic [NUM_ALARMS-1:0] pending,
  output logic                  irq,
  output logic [CNT_W-1:0]      coalesce_cnt,
  input  logic                  clr_cnt
`ifdef ATS21_ALARM_TS_EN
  ,
  output logic [TS_W-1:0]       evt_ts
`endif
);

  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic [NUM_ALARMS-1:0] r_alarm_q;
  logic [NUM_ALARMS-1:0] r_mask;
  logic [NUM_ALARMS-1:0] r_pending;
  logic [CNT_W-1:0]      r_cnt;

  logic [NUM_ALARMS-1:0] w_rise;
  logic [NUM_ALARMS-1:0] w_drain;
  logic [NUM_ALARMS-1:0] w_hold;
  logic [NUM_ALARMS-1:0] w_coal;
  logic [ID_W-1:0]       w_sel;
  logic                  w_any_pend;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_can_push;
  logic                  w_push;
  logic [31:0]           w_ncoal;
  logic [31:0]           w_cnt_sum;
  alarm_evt_t            w_push_evt;
  alarm_evt_t            w_head_evt;

  // Rising edge of an enabled alarm; alarm_q follows the raw input even when masked.
  assign w_rise = alarm_in & ~r_alarm_q & r_mask;

  assign w_pop      = ~w_empty & evt_ready;
  assign w_can_push = ~w_full | w_pop;
  assign w_push     = w_any_pend & w_can_push;

  // Lowest-index pending alarm wins the single push slot each cycle.
  always_comb begin
    w_sel      = '0;
    w_any_pend = 1'b0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_sel      = ID_W'(i);
        w_any_pend = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_drain
      assign w_drain[gi] = w_push & (w_sel == ID_W'(gi));
    end
  endgenerate

  // Bits that stay pending regardless of new rises; a rise landing on one of them is lost.
  assign w_hold = r_pending & ~w_drain;
  assign w_coal = w_rise & w_hold;

  // Number of events merged away this cycle.
  always_comb begin
    w_ncoal = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      w_ncoal = w_ncoal + 32'(w_coal[i]);
    end
  end

  assign w_cnt_sum = 32'(r_cnt) + w_ncoal;

  // Edge-detect history and host-writable enable mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alarm_q <= '0;
      r_mask    <= '1;
    end else begin
      r_alarm_q <= alarm_in;
      if (mask_wr) r_mask <= mask_data;
    end
  end

  // Sticky pending bits: set by a rise, cleared only when pushed into the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_hold | w_rise;
    end
  end

  // Saturating coalesce counter; an explicit clear beats any increment.
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      r_cnt <= '0;
    end else if (w_cnt_sum > CNT_MAX) begin
      r_cnt <= CNT_W'(CNT_MAX);
    end else begin
      r_cnt <= CNT_W'(w_cnt_sum);
    end
  end

`ifdef ATS21_ALARM_TS_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_ts_cap [NUM_ALARMS];

  // Free-running timebase, wraps.
  always_ff @(posedge clk) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 1'b1;
  end

  // Capture time only when a rise starts a new pending event; coalesced rises keep the first time.
  generate
    for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_ts_cap
      always_ff @(posedge clk) begin
        if (reset) begin
          r_ts_cap[gi] <= '0;
        end else if (w_rise[gi] && !w_hold[gi]) begin
          r_ts_cap[gi] <= r_ts;
        end
      end
    end
  endgenerate
`endif

  // Event word presented to the FIFO for the selected alarm.
  always_comb begin
    w_push_evt    = '0;
    w_push_evt.id = w_sel;
`ifdef ATS21_ALARM_TS_EN
    w_push_evt.ts = r_ts_cap[w_sel];
`endif
  end

  ats21_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_evt),
    .pop       (w_pop),
    .pop_data  (w_head_evt),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign evt_valid    = ~w_empty;
  assign irq          = ~w_empty;
  assign evt_id       = w_head_evt.id;
  assign pending      = r_pending;
  assign coalesce_cnt = r_cnt;
`ifdef ATS21_ALARM_TS_EN
  assign evt_ts       = w_head_evt.ts;
`endif

endmodule

// File: tb/tb_ats21_alarm_collector.sv
// Scoreboard bench for ats21_alarm_collector: directed pulses push expected IDs,
// a negedge monitor pops and compares on every accepted event.
module tb_ats21_alarm_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] alarm_in;
  logic        mask_wr;
  logic [23:0] mask_data;
  logic        evt_valid;
  logic [4:0]  evt_id;
  logic        evt_ready;
  logic [23:0] pending;
  logic        irq;
  logic [7:0]  coalesce_cnt;
  logic        clr_cnt;
`ifdef ATS21_ALARM_TS_EN
  logic [15:0] evt_ts;
  logic [15:0] ts_seen [32];
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q [$];
  logic [4:0] exp_id;

  always #5 clk = ~clk;

  ats21_alarm_collector dut (
    .clk          (clk),
    .reset        (reset),
    .alarm_in     (alarm_in),
    .mask_wr      (mask_wr),
    .mask_data    (mask_data),
    .evt_valid    (evt_valid),
    .evt_id       (evt_id),
    .evt_ready    (evt_ready),
    .pending      (pending),
    .irq          (irq),
    .coalesce_cnt (coalesce_cnt),
    .clr_cnt      (clr_cnt)
`ifdef ATS21_ALARM_TS_EN
    ,
    .evt_ts       (evt_ts)
`endif
  );

  // Monitor: every handshake pops one expected ID.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL evt_pop: got id %0d, expected no event", evt_id);
      end else begin
        exp_id = exp_q.pop_front();
        if (evt_id !== exp_id) begin
          n_errors++;
          $display("FAIL evt_pop: got id %0d, expected id %0d", evt_id, exp_id);
        end else begin
          $display("event id=%0d ok", evt_id);
        end
      end
`ifdef ATS21_ALARM_TS_EN
      ts_seen[evt_id] = evt_ts;
`endif
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("check %s = 0x%0h ok", name, act);
    end
  endtask

  // Two-cycle-high pulse like the ATS21 finished outputs.
  task automatic pulse(input logic [23:0] v);
    alarm_in = alarm_in | v;
    tick(2);
    alarm_in = alarm_in & ~v;
  endtask

  task automatic expect_id(input int id);
    exp_q.push_back(5'(id));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    evt_ready = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check({name, "_drained_left"}, 32'(exp_q.size()), 32'd0);
    tick(2);
    check({name, "_idle_valid"}, 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    alarm_in  = '0;
    mask_wr   = 1'b0;
    mask_data = '0;
    evt_ready = 1'b0;
    clr_cnt   = 1'b0;
    tick(2);
    check("rst_valid",   32'(evt_valid),    32'd0);
    check("rst_irq",     32'(irq),          32'd0);
    check("rst_id",      32'(evt_id),       32'd0);
    check("rst_pending", 32'(pending),      32'd0);
    check("rst_cnt",     32'(coalesce_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // Single pulse on alarm 5 with consumer ready: one event, valid two edges after rise.
    evt_ready = 1'b1;
    expect_id(5);
    alarm_in = 24'h000020;
    tick();
    check("t1_pending", 32'(pending),   32'h20);
    check("t1_valid0",  32'(evt_valid), 32'd0);
    tick();
    check("t1_valid1",  32'(evt_valid), 32'd1);
    check("t1_irq",     32'(irq),       32'd1);
    check("t1_id",      32'(evt_id),    32'd5);
    check("t1_pend_clr", 32'(pending),  32'd0);
    alarm_in = '0;
    tick();
    check("t1_valid_drop", 32'(evt_valid), 32'd0);
    check("t1_cnt",        32'(coalesce_cnt), 32'd0);
    tick(2);

    // Simultaneous pulses 0, 3, 17, consumer stalled: drained lowest first.
    evt_ready = 1'b0;
    expect_id(0); expect_id(3); expect_id(17);
    alarm_in = 24'h020009;
    tick();
    check("t2_pend_a", 32'(pending), 32'h020009);
    tick();
    check("t2_pend_b", 32'(pending), 32'h020008);
    check("t2_head",   32'(evt_id),  32'd0);
    alarm_in = '0;
    tick();
    check("t2_pend_c", 32'(pending), 32'h020000);
    tick();
    check("t2_pend_d", 32'(pending), 32'd0);
    check("t2_hold",   32'(evt_id),  32'd0);
    drain("t2");

    // Nine alarms into an eight-deep FIFO: ninth waits in pending.
    for (int i = 1; i <= 9; i++) expect_id(i);
    pulse(24'h0003FE);
    tick(10);
    check("t3_pend9",  32'(pending),      32'h200);
    check("t3_head",   32'(evt_id),       32'd1);
    check("t3_cnt",    32'(coalesce_cnt), 32'd0);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("t3_pend_after_pop", 32'(pending), 32'd0);
    check("t3_head_after_pop", 32'(evt_id),  32'd2);
    drain("t3");

    // FIFO full, alarm 2 pending, second pulse on 2 coalesces.
    for (int i = 10; i <= 17; i++) expect_id(i);
    expect_id(2);
    pulse(24'h03FC00);
    tick(8);
    pulse(24'h000004);
    check("t4_pend2", 32'(pending), 32'h4);
    tick();
    pulse(24'h000004);
    check("t4_cnt1",  32'(coalesce_cnt), 32'd1);
    check("t4_pend2b", 32'(pending),     32'h4);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("t4_cnt_clr", 32'(coalesce_cnt), 32'd0);
    drain("t4");

    // Masking alarm 4: masked pulse and mid-pulse unmask give nothing.
    mask_data = 24'hFFFFEF;
    mask_wr   = 1'b1;
    tick();
    mask_wr   = 1'b0;
    evt_ready = 1'b1;
    pulse(24'h000010);
    tick(3);
    check("t5_masked_pend",  32'(pending),   32'd0);
    check("t5_masked_valid", 32'(evt_valid), 32'd0);
    alarm_in  = 24'h000010;
    tick();
    mask_data = 24'hFFFFFF;
    mask_wr   = 1'b1;
    tick();
    mask_wr   = 1'b0;
    tick();
    alarm_in  = '0;
    tick(3);
    check("t5_unmask_pend",  32'(pending),   32'd0);
    check("t5_unmask_valid", 32'(evt_valid), 32'd0);
    expect_id(4);
    pulse(24'h000010);
    drain("t5");

    // Reset with three queued and one pending; input high through reset counts as a rise.
    evt_ready = 1'b0;
    pulse(24'h0003C0);
    tick(2);
    check("t6_pre_valid", 32'(evt_valid), 32'd1);
    check("t6_pre_pend",  32'(pending),   32'h200);
    reset    = 1'b1;
    alarm_in = 24'h100000;
    exp_q.delete();
    tick();
    check("t6_rst_valid", 32'(evt_valid), 32'd0);
    check("t6_rst_pend",  32'(pending),   32'd0);
    check("t6_rst_id",    32'(evt_id),    32'd0);
    reset = 1'b0;
    expect_id(20);
    tick(2);
    alarm_in = '0;
    drain("t6");

`ifdef ATS21_ALARM_TS_EN
    // Timestamps of two events whose rises are three cycles apart.
    expect_id(21); expect_id(22);
    pulse(24'h200000);
    tick();
    pulse(24'h400000);
    drain("t7");
    check("t7_ts_gap", 32'(16'(ts_seen[22] - ts_seen[21])), 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ats21_alarm_collector.md
Name: ats21_alarm_collector

Overview:
- Downstream consumer of the ATS21 `data[23:0]` alarm/timer "finished" outputs.
- Each `finished` bit is a 2-cycle-high pulse; this block converts each pulse into exactly one event.
- Events are queued as alarm IDs in a FIFO and presented to a host/interrupt controller over a valid/ready handshake with a level `irq`.
- Provides a per-alarm enable mask, sticky pending bits and a saturating coalesce counter.

Parameters:
- `NUM_ALARMS`, default 24: width of `alarm_in`, `pending` and `mask`.
- `ID_W`, default 5: event ID width, equal to $clog2(NUM_ALARMS).
- `FIFO_DEPTH`, default 8: event FIFO entries; must be a power of 2.
- `CNT_W`, default 8: width of the coalesce counter.
- `TS_W`, default 16: timestamp width (used only with the optional feature).

Ports:
- `clk` in 1: single clock, same clock as the ATS21 `clk`.
- `reset` in 1: synchronous, active-high reset.
- `alarm_in` in `NUM_ALARMS`: connected directly to ATS21 `data`.
- `mask_wr` in 1: on the clock edge where it is high, loads `mask_data` into the mask register.
- `mask_data` in `NUM_ALARMS`: new mask; 1 = alarm enabled.
- `evt_valid` out 1: FIFO head is valid.
- `evt_id` out `ID_W`: alarm number at the FIFO head.
- `evt_ready` in 1: consumer pop; the pop occurs when `evt_valid && evt_ready`.
- `pending` out `NUM_ALARMS`: sticky pending bits (events detected but not yet queued).
- `irq` out 1: equals `evt_valid` (level).
- `coalesce_cnt` out `CNT_W`: count of merged (lost) events.
- `clr_cnt` in 1: synchronous clear of `coalesce_cnt`.
- `evt_ts` out `TS_W`: timestamp at the FIFO head; exists only with `ATS21_ALARM_TS_EN`.

Behaviour:
- Reset values:
  - `alarm_q`, `pending`, FIFO pointers, occupancy count and `coalesce_cnt` = 0.
  - `mask` = all ones.
  - `evt_valid` = `irq` = 0; `evt_id` = 0.
  - Timestamp counter = 0.
- Reset asserted mid-operation discards all queued and pending events.
- Edge detect:
  - `alarm_q` <= `alarm_in` every cycle.
  - `rise[i]` = `alarm_in[i] & ~alarm_q[i] & mask[i]`.
  - A 2-cycle ATS21 pulse therefore yields exactly one `rise`.
  - An input already high on the first cycle after reset counts as a rise.
  - A masked alarm's edges are dropped, but `alarm_q` still tracks the input, so unmasking mid-pulse creates no event.
- Pending update, per bit each cycle: `pending[i]` <= (`pending[i] & ~drain[i]`) | `rise[i]`.
  - Rise on a bit that is pending and not drained this cycle: the bit stays set and `coalesce_cnt` increments, saturating at 2^CNT_W-1.
  - Multiple coalesces in the same cycle add their count.
  - Rise and drain on the same bit in the same cycle: the bit stays set (new event); not counted as a coalesce.
  - `clr_cnt` has priority over increment in the same cycle.
- Drain scanner:
  - Each cycle, select the lowest-index set `pending` bit.
  - Push its ID into the FIFO when there is space, i.e. `!full` or a pop is occurring this cycle.
  - Set `drain` one-hot for that bit.
  - At most one push per cycle.
- FIFO:
  - First-word fall-through; `evt_valid` = !empty.
  - `evt_id`/`evt_ts` hold steady while `evt_valid && !evt_ready`.
  - Push and pop in the same cycle leave occupancy unchanged, including when full or holding a single entry.
  - When full with no pop, `pending` retains events; nothing is lost except via coalescing.
  - Pointers wrap modulo `FIFO_DEPTH`; the occupancy counter is `$clog2(FIFO_DEPTH)+1` bits.
- Latency: a rise sampled at edge N sets `pending` at N, pushes at N+1, and `evt_valid` is seen high after edge N+1 (2 cycles from the input rise, FIFO not full).
- `mask_wr` applies to rises from the following cycle. It does not clear already-pending bits.

Optional Feature:
- Macro `ATS21_ALARM_TS_EN`.
- Defined:
  - A free-running `TS_W` counter (wraps) runs from reset.
  - A per-alarm timestamp register captures the counter value on a rise that sets a clear pending bit; a coalesced rise does not overwrite it.
  - The timestamp is pushed alongside the ID and presented on `evt_ts`.
- Undefined:
  - No counter, no timestamp storage and no `evt_ts` port.
  - FIFO width = `ID_W`.

Decomposition:
- Package `ats21_pkg` holds:
  - `NUM_ALARMS`, `ID_W` and `TS_W` constants.
  - Typedef `alarm_vec_t` (`logic [NUM_ALARMS-1:0]`).
  - Typedef `alarm_evt_t`: packed struct of the ID plus the timestamp under the macro.
- One sub-module, `ats21_evt_fifo`: a parameterized FWFT synchronous FIFO of `alarm_evt_t` with push/pop/full/empty.

Test Plan:
- Reset, then 2-cycle pulse on `alarm_in[5]`, `evt_ready`=1 -> exactly one event with `evt_id`=5; `evt_valid` high 2 cycles after the rise for 1 cycle; `coalesce_cnt`=0.
- Simultaneous pulses on bits 3, 0 and 17, `evt_ready`=0 -> FIFO holds 0, 3, 17 in that order; `pending` clears one bit per cycle; popping returns 0, 3, 17.
- `evt_ready`=0, pulses on 9 distinct alarms (`FIFO_DEPTH`=8) -> 8 queued, 9th remains in `pending`; after one pop it is queued next cycle; no coalesce.
- FIFO full, alarm 2 pending, second pulse on alarm 2 -> `coalesce_cnt`=1; only one ID 2 is eventually delivered; `clr_cnt` returns the count to 0.
- `mask_data`=all ones except bit 4, pulse on 4 -> no event; unmask during a high pulse -> no event; next pulse -> event ID 4.
- Reset asserted with 3 events queued -> next cycle `evt_valid`=0, `pending`=0; with the macro defined, `evt_ts` values for sequential events differ by the cycle gap between their rises.
